// File: rtl/int_request_unit_if.sv
// Purpose: handshake bundle between the interrupt request unit and the
//          system controller's interrupt sequencer.
// Signals:
//   int_pending - vector present / request valid (unit -> controller)
//   int_vector  - vector number of the presented request (unit -> controller)
//   int_ack     - controller accepted the vector, 1-cycle pulse (controller -> unit)
//   int_done    - controller finished interrupt entry, 1-cycle pulse (controller -> unit)
interface int_request_unit_if;
  logic       int_pending;
  logic [7:0] int_vector;
  logic       int_ack;
  logic       int_done;

  // Request source side.
  modport master (
    output int_pending,
    output int_vector,
    input  int_ack,
    input  int_done
  );

  // Interrupt sequencer side.
  modport slave (
    input  int_pending,
    input  int_vector,
    output int_ack,
    output int_done
  );
endinterface

// File: rtl/int_request_unit.sv
// Purpose: device-side interrupt source. Latches rising edges on int_in as
//          pending, presents the lowest-index unmasked pending line as a
//          vector, and tracks it as in-service until entry completes.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   int_in      - request lines, rising edge = request
//   int_mask    - 1 = line blocked from selection (still latched)
//   irq         - handshake bundle (int_pending/int_vector out, int_ack/int_done in)
//   in_service  - one-hot line currently being serviced
//   pend_bits   - raw pending register
module int_request_unit #(
  parameter int unsigned NUM_LINES = 8,
  parameter logic [7:0]  VEC_BASE  = 8'h20
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_LINES-1:0] int_in,
  input  logic [NUM_LINES-1:0] int_mask,
  int_request_unit_if.master   irq,
  output logic [NUM_LINES-1:0] in_service,
  output logic [NUM_LINES-1:0] pend_bits
);

  localparam int unsigned IDX_W = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_e;

  state_e               state_q;
  logic [NUM_LINES-1:0] int_in_q;
  logic [NUM_LINES-1:0] pend_q;
  logic [NUM_LINES-1:0] in_service_q;
  logic                 armed_q;
  logic                 int_pending_q;
  logic [7:0]           int_vector_q;
  logic [IDX_W-1:0]     idx_q;

  logic [NUM_LINES-1:0] rise_c;
  logic [NUM_LINES-1:0] eligible_c;
  logic [NUM_LINES-1:0] idx_onehot_c;
  logic [NUM_LINES-1:0] pend_d;
  logic [IDX_W-1:0]     win_idx_c;
  logic                 any_eligible_c;
  logic                 ack_take_c;

  // Edge detect, fixed-priority pick and pending next-state.
  // armed_q is low for the first cycle out of reset: that sample only
  // establishes the int_in baseline, so a line held high through reset
  // is not mistaken for a fresh edge.
  always_comb begin
    rise_c         = armed_q ? (int_in & ~int_in_q) : '0;
    eligible_c     = pend_q & ~int_mask;
    any_eligible_c = |eligible_c;
    win_idx_c      = '0;
    // Descending scan so the lowest eligible index is the last write.
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      if (eligible_c[i]) win_idx_c = IDX_W'(i);
    end
    idx_onehot_c = NUM_LINES'(1) << idx_q;
    ack_take_c   = (state_q == REQ) && irq.int_ack;
    // Clear on ack first, then OR in new edges so a same-cycle edge wins.
    pend_d       = (pend_q & ~(ack_take_c ? idx_onehot_c : '0)) | rise_c;
  end

  // Request/acknowledge/service sequencer with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      int_in_q      <= '0;
      pend_q        <= '0;
      in_service_q  <= '0;
      armed_q       <= 1'b0;
      int_pending_q <= 1'b0;
      int_vector_q  <= 8'h00;
      idx_q         <= '0;
    end else begin
      armed_q  <= 1'b1;
      int_in_q <= int_in;
      pend_q   <= pend_d;
      case (state_q)
        IDLE: begin
          if (any_eligible_c) begin
            idx_q         <= win_idx_c;
            int_vector_q  <= VEC_BASE + 8'(win_idx_c);
            int_pending_q <= 1'b1;
            state_q       <= REQ;
          end
        end
        REQ: begin
          // Vector is frozen here; int_done is ignored even alongside ack.
          if (irq.int_ack) begin
            in_service_q  <= idx_onehot_c;
            int_pending_q <= 1'b0;
            state_q       <= SERVICE;
          end
        end
        SERVICE: begin
          if (irq.int_done) begin
            in_service_q <= '0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign irq.int_pending = int_pending_q;
  assign irq.int_vector  = int_vector_q;
  assign in_service      = in_service_q;
  assign pend_bits       = pend_q;

endmodule
